// File: rtl/eight_bit_1_4_demux_reg_pkg.sv
// Shared constants for the registered 8-bit 1-to-4 demultiplexer.
// Channel codes match the {s1,s0} select and the round-robin pointer values.
package eight_bit_1_4_demux_reg_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned NCH_FIXED     = 4;

    typedef enum logic [1:0] {
        CH_A = 2'b00,
        CH_B = 2'b01,
        CH_C = 2'b10,
        CH_D = 2'b11
    } ch_e;

endpackage

// File: rtl/eight_bit_1_4_demux_reg_channel.sv
// One demux slice: holding register, valid flag and sticky overrun flag.
module demux_channel_reg
    import eight_bit_1_4_demux_reg_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel_wr,
    input  logic [WIDTH-1:0] in,
    input  logic             ack,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             ovf
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (sel_wr) begin
            data <= in;
        end
    end

    // A write in the same cycle as an ack refills the slot, so valid stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (sel_wr) begin
            valid <= 1'b1;
        end else if (ack) begin
            valid <= 1'b0;
        end
    end

    // Overrun set takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (sel_wr && valid && !ack) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/eight_bit_1_4_demux_reg.sv
// Registered 8-bit 1-to-4 demultiplexer: steers a write into one of four
// holding registers chosen by {s1,s0} or a round-robin pointer.
module eight_bit_1_4_demux_reg
    import eight_bit_1_4_demux_reg_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned NCH   = NCH_FIXED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             s0,
    input  logic             s1,
    input  logic             wr,
    input  logic             auto,
    input  logic [NCH-1:0]   ack,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [NCH-1:0]   valid,
    output logic [NCH-1:0]   ovf,
    output logic [1:0]       ptr
);

    ch_e              tgt;
    logic [NCH-1:0]   sel_wr;
    logic [WIDTH-1:0] ch_data [NCH];

    always_comb begin
        tgt = auto ? ch_e'(ptr) : ch_e'({s1, s0});
    end

    // Decode only under wr so an unknown select cannot reach any slice.
    always_comb begin
        sel_wr = '0;
        if (wr) begin
            sel_wr[tgt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (wr && auto) begin
            ptr <= ptr + 2'd1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        demux_channel_reg #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .sel_wr  (sel_wr[g]),
            .in      (in),
            .ack     (ack[g]),
            .clr_ovf (clr_ovf),
            .data    (ch_data[g]),
            .valid   (valid[g]),
            .ovf     (ovf[g])
        );
    end

    assign a = ch_data[CH_A];
    assign b = ch_data[CH_B];
    assign c = ch_data[CH_C];
    assign d = ch_data[CH_D];

endmodule

// File: tb/tb_eight_bit_1_4_demux_reg.sv
// Bench for eight_bit_1_4_demux_reg: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_eight_bit_1_4_demux_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in;
    logic       s0, s1, wr, auto, clr_ovf;
    logic [3:0] ack;
    logic [7:0] a, b, c, d;
    logic [3:0] valid, ovf;
    logic [1:0] ptr;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    eight_bit_1_4_demux_reg #(
        .WIDTH (8),
        .NCH   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .s0      (s0),
        .s1      (s1),
        .wr      (wr),
        .auto    (auto),
        .ack     (ack),
        .clr_ovf (clr_ovf),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .valid   (valid),
        .ovf     (ovf),
        .ptr     (ptr)
    );

    always #5 clk = ~clk;

    // Behavioural model: four slots, each with data, a pending flag and a loss flag.
    logic [7:0] m_data [4];
    logic [3:0] m_valid, m_ovf;
    int         m_ptr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
            m_valid = 4'b0000;
            m_ovf   = 4'b0000;
            m_ptr   = 0;
        end else begin
            int t;
            t = auto ? m_ptr : (s1 ? 2 : 0) + (s0 ? 1 : 0);
            if (clr_ovf) m_ovf = 4'b0000;
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) m_valid[i] = 1'b0;
            end
            if (wr) begin
                // Loss happens only if the slot was pending and not consumed now.
                if (m_valid[t] == 1'b1 || (ack[t] == 1'b0 && 1'b0)) m_ovf[t] = 1'b1;
                m_data[t]  = in;
                m_valid[t] = 1'b1;
                if (auto) m_ptr = (m_ptr + 1) % 4;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a", a, m_data[0]);
            check("b", b, m_data[1]);
            check("c", c, m_data[2]);
            check("d", d, m_data[3]);
            check("valid", valid, m_valid);
            check("ovf", ovf, m_ovf);
            check("ptr", ptr, m_ptr[1:0]);
        end
    end

    task automatic idle();
        wr = 1'b0; ack = 4'b0000; clr_ovf = 1'b0;
    endtask

    task automatic cyc(input logic w, input logic au, input logic [1:0] sel,
                       input logic [7:0] data, input logic [3:0] ak, input logic clr);
        wr = w; auto = au; {s1, s0} = sel; in = data; ack = ak; clr_ovf = clr;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; in = '0; s0 = 0; s1 = 0; auto = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_a", a, 8'h00);
        check("rst_valid", valid, 4'b0000);
        check("rst_ptr", ptr, 2'b00);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // Async reset mid-cycle clears everything without a clock edge.
        cyc(1, 0, 2'b10, 8'hFF, 4'b0000, 0);
        cyc(1, 0, 2'b10, 8'hFF, 4'b0000, 0);
        cyc(1, 1, 2'b00, 8'h12, 4'b0000, 0);
        check("pre_rst_ovf", ovf, 4'b0100);
        check("pre_rst_ptr", ptr, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("async_c", c, 8'h00);
        check("async_valid", valid, 4'b0000);
        check("async_ovf", ovf, 4'b0000);
        check("async_ptr", ptr, 2'b00);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Manual writes to c then b.
        cyc(1, 0, 2'b10, 8'hA5, 4'b0000, 0);
        cyc(1, 0, 2'b01, 8'h3C, 4'b0000, 0);
        check("t2_c", c, 8'hA5);
        check("t2_b", b, 8'h3C);
        check("t2_a", a, 8'h00);
        check("t2_d", d, 8'h00);
        check("t2_valid", valid, 4'b0110);
        check("t2_ptr", ptr, 2'b00);
        check("model_c", m_data[2], 8'hA5);
        check("model_valid", m_valid, 4'b0110);

        // Round-robin with wrap and overrun on a.
        reset_pulse();
        cyc(1, 1, 2'b00, 8'h11, 4'b0000, 0);
        cyc(1, 1, 2'b11, 8'h22, 4'b0000, 0);
        cyc(1, 1, 2'b00, 8'h33, 4'b0000, 0);
        cyc(1, 1, 2'b01, 8'h44, 4'b0000, 0);
        check("t3_ptr_wrap", ptr, 2'b00);
        cyc(1, 1, 2'b10, 8'h55, 4'b0000, 0);
        check("t3_a", a, 8'h55);
        check("t3_b", b, 8'h22);
        check("t3_c", c, 8'h33);
        check("t3_d", d, 8'h44);
        check("t3_ptr", ptr, 2'b01);
        check("t3_ovf", ovf, 4'b0001);
        check("model_ovf", m_ovf, 4'b0001);

        // Write and ack on the same channel: no overrun, stays valid.
        cyc(1, 0, 2'b10, 8'h7E, 4'b0100, 0);
        check("t4_c", c, 8'h7E);
        check("t4_valid2", valid[2], 1'b1);
        check("t4_ovf2", ovf[2], 1'b0);
        cyc(0, 0, 2'b00, 8'h00, 4'b0100, 0);
        check("t4_ack_valid2", valid[2], 1'b0);
        check("t4_ack_c", c, 8'h7E);

        // Overrun set wins over clear in the same cycle.
        cyc(1, 0, 2'b11, 8'h66, 4'b0000, 0);
        check("t5_ovf_pre", ovf, 4'b1001);
        cyc(1, 0, 2'b11, 8'h77, 4'b0000, 1);
        check("t5_ovf3", ovf[3], 1'b1);
        check("t5_ovf", ovf, 4'b1000);
        cyc(0, 0, 2'b00, 8'h00, 4'b0000, 1);
        check("t5_clr", ovf, 4'b0000);

        // Idle cycles with toggling selects leave state alone.
        for (int k = 0; k < 5; k++) begin
            cyc(0, k[0], k[1:0], 8'hEE, 4'b0000, 0);
        end
        check("t6_a", a, 8'h55);
        check("t6_b", b, 8'h22);
        check("t6_c", c, 8'h7E);
        check("t6_d", d, 8'h77);
        check("t6_valid", valid, 4'b1011);
        check("t6_ptr", ptr, 2'b01);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            wr      = ($urandom_range(0, 9) < 6);
            auto    = $urandom_range(0, 1);
            s0      = $urandom_range(0, 1);
            s1      = $urandom_range(0, 1);
            in      = 8'($urandom);
            ack     = 4'($urandom & $urandom);
            clr_ovf = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
            if (k % 500 == 250) reset_pulse();
        end
        idle();
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/eight_bit_1_4_demux_reg.md
Name: eight_bit_1_4_demux_reg

Overview:
Registered 8-bit 1-to-4 demultiplexer. It is the distribution counterpart of the 8-bit 4:1 selector.
- A write strobe steers one input byte into one of four holding registers (a..d).
- Selection is by s1:s0 or by an internal round-robin pointer.
- Each channel carries a valid flag, an acknowledge, and a sticky overrun flag.
- Sits between the datapath result bus and four downstream consumers.

Parameters:
WIDTH, 8, data width of input and of each channel register
NCH, 4, channel count; fixed at 4 (2-bit select); other values unsupported

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in  input  WIDTH  write data
s0  input  1  select LSB (manual mode)
s1  input  1  select MSB (manual mode)
wr  input  1  write strobe, one write per cycle high
auto  input  1  1 = target is round-robin pointer; 0 = target is {s1,s0}
ack  input  NCH  per-channel consume; bit0=a, bit1=b, bit2=c, bit3=d
clr_ovf  input  1  synchronous clear of all overrun flags
a  output  WIDTH  channel 0 register ({s1,s0}=00)
b  output  WIDTH  channel 1 register (01)
c  output  WIDTH  channel 2 register (10)
d  output  WIDTH  channel 3 register (11)
valid  output  NCH  channel holds unconsumed data
ovf  output  NCH  sticky: unconsumed data was overwritten
ptr  output  2  round-robin pointer

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately): a=b=c=d=0, valid=0000, ovf=0000, ptr=00. All state is held while rst_n is low. The first edge after release behaves normally.
- Target: tgt = auto ? ptr : {s1,s0}. It is evaluated combinationally in the write cycle.
- Write, latency 1: on a rising edge with wr=1, the tgt register <= in and valid[tgt] <= 1. Outputs change on that edge only; no combinational path from in to a..d.
- Only the tgt register changes on a write; the other three hold.
- wr=0: no register or pointer change, regardless of s0/s1/auto.
- ack[i]=1 at an edge clears valid[i]. Data in register i is retained; it is not zeroed.
- ack on a channel with valid=0 is ignored; no error.
- Multiple ack bits may be high together; each acts independently.
- Overrun: on wr to channel i with valid[i]=1 and ack[i]=0, ovf[i] <= 1 (sticky). The new data still overwrites.
- Simultaneous wr to i and ack[i] at the same edge: old data is consumed, new data is written, valid[i] stays 1, no overrun.
- clr_ovf=1 clears all ovf bits at the edge. If an overrun occurs in the same cycle, set wins for that bit.
- Pointer: ptr increments by 1 mod 4 only on an edge with wr=1 and auto=1; it wraps 11->00.
- Manual-mode writes do not move ptr. Switching auto mid-stream keeps ptr where it is.
- No backpressure: writes are always accepted. Loss is reported only via ovf.
- X on s0/s1 while wr=0 must not corrupt state.

Decomposition:
- Shared package constants: CH_A=2'b00, CH_B=2'b01, CH_C=2'b10, CH_D=2'b11, WIDTH default 8.
- One sub-module, demux_channel_reg: holds data, valid, and ovf for one channel. Inputs: clk, rst_n, sel_wr, in, ack, clr_ovf. Instantiated four times, mirroring the per-slice structural style of the selector.
- Top level: target decode, pointer counter, instantiation.

Test Plan:
1. Reset pulse mid-run after writing 8'hFF to c -> immediately c=00, valid=0000, ovf=0000, ptr=00, without waiting for a clock edge.
2. auto=0, wr with {s1,s0}=10 and in=8'hA5, next cycle wr with 01 and in=8'h3C -> c=A5, b=3C, valid=0110, a=d=00, ptr=00.
3. auto=1, four consecutive writes 11,22,33,44, then a fifth write 55 -> a=55, b=22, c=33, d=44, ptr=01, ovf=0001 (a overwritten while valid).
4. valid[2]=1, same edge wr to c with in=8'h7E and ack=0100 -> c=7E, valid[2]=1, ovf[2]=0. Next edge ack=0100 only -> valid[2]=0, c still 7E.
5. ovf=1000 with clr_ovf=1, and at the same edge an overrun write to d -> ovf[3]=1. Next edge clr_ovf=1, wr=0 -> ovf=0000.
6. wr=0 for 5 cycles with s0/s1/auto toggling and ack=0000 -> a..d, valid, and ptr unchanged.
